aidan_mcnay_sipo_ctrl: RTL and testbench
========================================

# aidan_mcnay_sipo_ctrl

Sequencing controller for the `aidan_mcnay_sipo` shift register in the prime-detection datapath. It accepts a bit-serial operand through a val/rdy stream and drives the SIPO's `en`/`data_in`. It counts exactly `nbits` accepted bits, then presents the completed parallel word to the downstream detector with a val/rdy handshake. It holds off further serial input until the word is consumed.

## Interface
- `nbits`, default 16: operand width; must match the attached SIPO's `nbits`; legal range 1..32.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous abort of the current frame.
- `ser_val` input 1: serial bit valid.
- `ser_data` input 1: serial bit, MSB of the operand first.
- `ser_rdy` output 1: controller can accept a serial bit.
- `sipo_en` output 1: shift enable, wired to SIPO `en`.
- `sipo_data` output 1: wired to SIPO `data_in`.
- `par_val` output 1: SIPO `data_out` holds a complete operand.
- `par_rdy` input 1: downstream accepts the operand.
- `bit_count` output $clog2(nbits+1): bits accepted in the current frame.
- `busy` output 1: frame in progress or awaiting hand-off (state != IDLE).

## Operation
- States: IDLE, SHIFT, DONE. Bit counter width is $clog2(nbits+1).
- Bit transfer occurs when `ser_val && ser_rdy && !clear`.
- `ser_rdy` = (state is IDLE or SHIFT) && !clear.
- `sipo_en` = transfer, combinational.
- `sipo_data` = `ser_data`, pass-through.
- IDLE:
  - On transfer: `bit_count` becomes 1.
  - Next state is SHIFT, or DONE if `nbits` == 1.
- SHIFT:
  - On transfer: `bit_count` increments.
  - If `bit_count` was `nbits`-1, next state is DONE and `bit_count` = `nbits`.
  - With no transfer, state holds. Gaps in `ser_val` are legal at any point.
- DONE:
  - `ser_rdy` = 0 and `sipo_en` = 0, so SIPO contents are frozen.
  - `par_val` = 1.
  - On `par_val && par_rdy`: next state IDLE, `bit_count` = 0.
  - Otherwise hold indefinitely.
- `ser_val` asserted while in DONE is ignored. No bit is lost, because `ser_rdy` = 0 and the source must hold the bit.
- `clear` has priority over every transition:
  - Next state IDLE, `bit_count` = 0.
  - `sipo_en` and `ser_rdy` are forced 0 in the `clear` cycle.
  - Stale SIPO contents are not zeroed; they are overwritten by the next frame.
  - `par_val` stays high during a `clear` cycle in DONE. A simultaneous `par_rdy` still counts as a hand-off.
- `reset` (async):
  - Immediately forces IDLE, `bit_count` = 0, `par_val` = 0, `busy` = 0.
  - `ser_rdy` = 1 once `clear` is low.
  - Legal mid-frame; the partial frame is discarded.

## Timing
- Reset values: state IDLE, `bit_count` 0, `par_val` 0, `busy` 0, `sipo_en` 0. `ser_rdy` = !`clear`; `sipo_data` follows `ser_data`.
- `par_val`, `busy` and `bit_count` are registered (Moore). `ser_rdy` and `sipo_en` are combinational.
- Latency:
  - The last bit is accepted in cycle k; the SIPO captures it at edge k.
  - `par_val` rises in cycle k+1, aligned with valid `data_out`.
- Hand-off completes at the edge where `par_val && par_rdy`. `ser_rdy` returns to 1 in the following cycle.
- No same-cycle DONE→SHIFT bypass. Minimum frame period is `nbits`+1 cycles.
- With continuous `ser_val` and `par_rdy` = 1, the stream runs at 16 bits per 17 cycles (`nbits` = 16).

## Test plan
- **Back-to-back frames:** reset, then stream 0xB3A7 MSB-first with `ser_val` = 1 and `par_rdy` = 1 → `sipo_en` high for 16 cycles; `par_val` high for exactly 1 cycle, in cycle 17; SIPO `data_out` = 0xB3A7; `bit_count` 0→16→0. A second word, 0x0001, follows with one bubble cycle.
- **Gapped input and backpressure:** random gaps in `ser_val`, `par_rdy` held 0 for 5 cycles after DONE → `par_val` and `data_out` = 0xB3A7 stable for 6 cycles. `ser_rdy` = 0 and `sipo_en` = 0 throughout, even with `ser_val` = 1.
- **Clear mid-frame:** `clear` after 9 bits → `bit_count` = 0 and state IDLE next cycle. A new full frame of 0x1F3D then yields `par_val` with `data_out` = 0x1F3D.
- **Async reset mid-frame:** assert `reset` between clock edges at `bit_count` 5 → `busy`, `par_val` and `bit_count` drop to 0 before the next edge. A subsequent frame of 0xFFFF completes normally.
- **Clear in DONE:** `clear` and `par_rdy` high together in DONE → exactly one hand-off counted, next state IDLE.
- **Single-bit build:** `nbits` = 1, bits 1 then 0 → `par_val` in the cycle after each bit, with `data_out` 1 then 0.

Source files
------------

// File: rtl/aidan_mcnay_sipo_ctrl.sv
// rtl/aidan_mcnay_sipo_ctrl.sv - serial-in/parallel-out sequencing controller
//
// Accepts a bit-serial operand (MSB first) on a val/rdy stream, drives the
// attached SIPO shift register, counts nbits accepted bits, then presents the
// completed word downstream with a val/rdy hand-off.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   clear      synchronous abort of the current frame
//   ser_val    serial bit valid
//   ser_data   serial bit
//   ser_rdy    controller can accept a serial bit
//   sipo_en    SIPO shift enable
//   sipo_data  SIPO serial data in
//   par_val    SIPO data_out holds a complete operand
//   par_rdy    downstream accepts the operand
//   bit_count  bits accepted in the current frame
//   busy       frame in progress or awaiting hand-off
module aidan_mcnay_sipo_ctrl #(
   parameter int nbits = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         ser_val,
   input  logic                         ser_data,
   output logic                         ser_rdy,
   output logic                         sipo_en,
   output logic                         sipo_data,
   output logic                         par_val,
   input  logic                         par_rdy,
   output logic [$clog2(nbits+1)-1:0]   bit_count,
   output logic                         busy
);

   localparam int CW = $clog2(nbits + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(nbits - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(nbits);

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [CW-1:0] count_next;
   logic          xfer;

   // clear blocks acceptance so an aborted cycle never shifts the SIPO
   assign ser_rdy   = ((state == IDLE) || (state == SHIFT)) && !clear;
   assign xfer      = ser_val && ser_rdy;
   assign sipo_en   = xfer;
   assign sipo_data = ser_data;

   // Moore outputs decoded straight from the state register
   assign par_val = (state == DONE);
   assign busy    = (state != IDLE);

   always_comb begin
      state_next = state;
      count_next = bit_count;
      if (clear) begin
         // abort wins over every transition, including a DONE hand-off
         state_next = IDLE;
         count_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  count_next = CNT_ONE;
                  state_next = (nbits == 1) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               if (xfer) begin
                  if (bit_count == CNT_LAST) begin
                     count_next = CNT_FULL;
                     state_next = DONE;
                  end else begin
                     count_next = bit_count + CNT_ONE;
                  end
               end
            end
            DONE: begin
               if (par_rdy) begin
                  state_next = IDLE;
                  count_next = '0;
               end
            end
            default: begin
               state_next = IDLE;
               count_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_count <= '0;
      end else begin
         state     <= state_next;
         bit_count <= count_next;
      end
   end

endmodule

// File: tb/tb_aidan_mcnay_sipo_ctrl.sv
// tb/tb_aidan_mcnay_sipo_ctrl.sv - directed self-checking bench for aidan_mcnay_sipo_ctrl
module tb_aidan_mcnay_sipo_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       ser_val = 1'b0;
   logic       ser_data = 1'b0;
   logic       par_rdy = 1'b0;
   logic       ser_rdy, sipo_en, sipo_data, par_val, busy;
   logic [4:0] bit_count;

   logic       clear1 = 1'b0;
   logic       ser_val1 = 1'b0;
   logic       ser_data1 = 1'b0;
   logic       par_rdy1 = 1'b0;
   logic       ser_rdy1, sipo_en1, sipo_data1, par_val1, busy1;
   logic [0:0] bit_count1;

   logic [15:0] sh = 16'h0;
   logic        sh1 = 1'b0;
   int          hand = 0;
   int          h0;
   int          passes = 0;
   int          total = 0;

   aidan_mcnay_sipo_ctrl #(.nbits(16)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .ser_val(ser_val), .ser_data(ser_data), .ser_rdy(ser_rdy),
      .sipo_en(sipo_en), .sipo_data(sipo_data),
      .par_val(par_val), .par_rdy(par_rdy),
      .bit_count(bit_count), .busy(busy)
   );

   aidan_mcnay_sipo_ctrl #(.nbits(1)) dut1 (
      .clk(clk), .reset(reset), .clear(clear1),
      .ser_val(ser_val1), .ser_data(ser_data1), .ser_rdy(ser_rdy1),
      .sipo_en(sipo_en1), .sipo_data(sipo_data1),
      .par_val(par_val1), .par_rdy(par_rdy1),
      .bit_count(bit_count1), .busy(busy1)
   );

   always #5 clk = ~clk;

   // reference SIPO registers and hand-off counter
   always @(posedge clk) begin
      if (sipo_en) sh <= {sh[14:0], sipo_data};
      if (sipo_en1) sh1 <= sipo_data1;
      if (par_val && par_rdy) hand <= hand + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // drive n bits of w MSB-first; optional bubbles in ser_val
   task automatic send(input logic [15:0] w, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && (i % 3 == 1)) begin
            ser_val = 1'b0;
            #1;
            chk("gap_en", {31'b0, sipo_en}, 32'd0);
            cyc();
         end
         ser_val  = 1'b1;
         ser_data = w[15-i];
         #1;
         chk("bit_en", {31'b0, sipo_en}, 32'd1);
         chk("bit_cnt", {27'b0, bit_count}, i);
         chk("bit_pv", {31'b0, par_val}, 32'd0);
         cyc();
      end
      ser_val = 1'b0;
   endtask

   initial begin
      // reset state
      #1;
      chk("rst_cnt", {27'b0, bit_count}, 32'd0);
      chk("rst_pv", {31'b0, par_val}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_en", {31'b0, sipo_en}, 32'd0);
      chk("rst_rdy", {31'b0, ser_rdy}, 32'd1);
      cyc();
      cyc();
      reset = 1'b0;

      // back-to-back frames
      par_rdy = 1'b1;
      send(16'hB3A7, 16, 1'b0);
      ser_val  = 1'b1;
      ser_data = 1'b0;
      #1;
      chk("b2b_pv", {31'b0, par_val}, 32'd1);
      chk("b2b_data", {16'b0, sh}, 32'hB3A7);
      chk("b2b_cnt", {27'b0, bit_count}, 32'd16);
      chk("b2b_rdy", {31'b0, ser_rdy}, 32'd0);
      chk("b2b_en", {31'b0, sipo_en}, 32'd0);
      cyc();
      #1;
      chk("b2b_pv_fall", {31'b0, par_val}, 32'd0);
      chk("b2b_cnt0", {27'b0, bit_count}, 32'd0);
      send(16'h0001, 16, 1'b0);
      #1;
      chk("w2_pv", {31'b0, par_val}, 32'd1);
      chk("w2_data", {16'b0, sh}, 32'h0001);
      cyc();

      // gapped input and backpressure
      par_rdy = 1'b0;
      send(16'hB3A7, 16, 1'b1);
      ser_val = 1'b1;
      for (int c = 0; c < 6; c++) begin
         par_rdy = (c == 5);
         #1;
         chk("bp_pv", {31'b0, par_val}, 32'd1);
         chk("bp_data", {16'b0, sh}, 32'hB3A7);
         chk("bp_rdy", {31'b0, ser_rdy}, 32'd0);
         chk("bp_en", {31'b0, sipo_en}, 32'd0);
         cyc();
      end
      ser_val = 1'b0;
      par_rdy = 1'b0;
      #1;
      chk("bp_pv_fall", {31'b0, par_val}, 32'd0);
      chk("bp_rdy_back", {31'b0, ser_rdy}, 32'd1);
      cyc();

      // clear mid-frame
      send(16'hA5A5, 9, 1'b0);
      clear   = 1'b1;
      ser_val = 1'b1;
      #1;
      chk("clr_rdy", {31'b0, ser_rdy}, 32'd0);
      chk("clr_en", {31'b0, sipo_en}, 32'd0);
      chk("clr_busy", {31'b0, busy}, 32'd1);
      cyc();
      clear   = 1'b0;
      ser_val = 1'b0;
      #1;
      chk("clr_cnt", {27'b0, bit_count}, 32'd0);
      chk("clr_idle", {31'b0, busy}, 32'd0);
      send(16'h1F3D, 16, 1'b0);
      #1;
      chk("clr_pv", {31'b0, par_val}, 32'd1);
      chk("clr_data", {16'b0, sh}, 32'h1F3D);

      // clear together with par_rdy in DONE
      h0      = hand;
      clear   = 1'b1;
      par_rdy = 1'b1;
      #1;
      chk("cd_pv", {31'b0, par_val}, 32'd1);
      cyc();
      clear = 1'b0;
      #1;
      chk("cd_busy", {31'b0, busy}, 32'd0);
      chk("cd_pv0", {31'b0, par_val}, 32'd0);
      chk("cd_cnt", {27'b0, bit_count}, 32'd0);
      cyc();
      par_rdy = 1'b0;
      chk("cd_hand", hand, h0 + 1);

      // async reset mid-frame
      send(16'h0000, 5, 1'b0);
      #1;
      chk("ar_cnt5", {27'b0, bit_count}, 32'd5);
      #3;
      reset = 1'b1;
      #1;
      chk("ar_busy", {31'b0, busy}, 32'd0);
      chk("ar_pv", {31'b0, par_val}, 32'd0);
      chk("ar_cnt", {27'b0, bit_count}, 32'd0);
      chk("ar_rdy", {31'b0, ser_rdy}, 32'd1);
      cyc();
      reset = 1'b0;
      send(16'hFFFF, 16, 1'b0);
      #1;
      chk("ar_frame_pv", {31'b0, par_val}, 32'd1);
      chk("ar_frame_data", {16'b0, sh}, 32'hFFFF);
      par_rdy = 1'b1;
      cyc();
      par_rdy = 1'b0;

      // single-bit build
      ser_val1  = 1'b1;
      ser_data1 = 1'b1;
      #1;
      chk("n1_en1", {31'b0, sipo_en1}, 32'd1);
      chk("n1_pv_pre", {31'b0, par_val1}, 32'd0);
      cyc();
      ser_val1 = 1'b0;
      par_rdy1 = 1'b1;
      #1;
      chk("n1_pv1", {31'b0, par_val1}, 32'd1);
      chk("n1_data1", {31'b0, sh1}, 32'd1);
      chk("n1_cnt", {31'b0, bit_count1}, 32'd1);
      cyc();
      par_rdy1  = 1'b0;
      ser_val1  = 1'b1;
      ser_data1 = 1'b0;
      #1;
      chk("n1_en2", {31'b0, sipo_en1}, 32'd1);
      chk("n1_pv_mid", {31'b0, par_val1}, 32'd0);
      cyc();
      ser_val1 = 1'b0;
      #1;
      chk("n1_pv2", {31'b0, par_val1}, 32'd1);
      chk("n1_data2", {31'b0, sh1}, 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
